// File: rtl/bit_merge32.sv
// Serial-to-parallel word assembler: gathers accepted bits into a WIDTH-bit word
// and holds each completed word in a one-entry output register with valid/ready.
module bit_merge32 #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    input  logic                       word_clear,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun
);

    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  cand;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     pos;
    logic              accept;
    logic              last;
    logic              load;
    logic              drop;

    // Candidate word is the accumulator with the incoming bit already placed,
    // so a completing bit is visible in word_out the cycle after it arrives.
    always_comb begin
        accept = bit_valid && !word_clear;
        last   = accept && (cnt == CW'(WIDTH-1));
        pos    = LSB_FIRST ? cnt : (CW'(WIDTH-1) - cnt);
        cand   = acc;
        for (int i = 0; i < WIDTH; i++) begin
            if (pos == CW'(i)) begin
                cand[i] = bit_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (last) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (word_ready) begin
                    if (last) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end else if (last) begin
                    drop = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            acc      <= '0;
            cnt      <= '0;
            word_out <= '0;
            overrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            // Clear and completion both leave acc zero-filled for the next word.
            if (word_clear || last) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= cand;
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                word_out <= cand;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    assign word_valid = (state == FULL);
    assign bit_count  = cnt;

endmodule

// File: doc/bit_merge32.md
# bit_merge32

Bit-serial to parallel word assembler: collects single-bit samples into a 32-bit word and presents each completed word on a registered output with a valid/ready handshake. It is the gathering counterpart of the 32-way bit splitter. Single-bit lanes or a serial bit stream enter here and leave as a parallel bus for downstream word-wide logic. The input side is never back-pressured, so loss is flagged explicitly via `overrun`.

## Interface
Parameters:
- `WIDTH`, default 32: bits per assembled word; valid range 2..64.
- `LSB_FIRST`, default 1: 1 = first accepted bit lands in `word_out[0]`; 0 = first bit lands in `word_out[WIDTH-1]`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` is accepted on this edge; no ready/back-pressure on this side.
- `word_clear`  in  1  discard the partially assembled word.
- `word_out`  out  WIDTH  assembled word, registered; stable while `word_valid`=1.
- `word_valid`  out  1  `word_out` holds an untaken word.
- `word_ready`  in  1  consumer takes `word_out` on an edge where `word_valid`&&`word_ready`.
- `bit_count`  out  clog2(WIDTH+1)  bits currently held in the partial word, range 0..WIDTH-1.
- `overrun`  out  1  sticky flag: a completed word was dropped.

## Operation
- **Datapath:** shift/index register `acc` (WIDTH bits) and counter `cnt`.
- **Bit placement:** on an accepted bit (`bit_valid`=1 and `word_clear`=0), the bit is written to position `cnt` when `LSB_FIRST`=1, or to position `WIDTH-1-cnt` when `LSB_FIRST`=0. `cnt` then increments.
- **Word completion:** occurs when the accepted bit is bit number WIDTH (`cnt`==WIDTH-1).
  - `cnt` wraps to 0.
  - The complete word (`acc` including this bit) is the candidate for the output register.
- **Output register, two states:**
  - EMPTY (`word_valid`=0): a candidate is loaded into `word_out`; go to FULL.
  - FULL (`word_valid`=1):
    - Handshake with no candidate: go to EMPTY; `word_out` keeps its last value.
    - Handshake and candidate on the same edge: load the candidate; stay FULL.
    - No handshake and a candidate: the candidate is dropped, `word_out` is unchanged, `overrun` is set to 1.
- **`overrun`:** cleared only by `rst`.
- **`word_clear`:**
  - Sets `cnt` to 0 and `acc` to 0.
  - Has priority over a simultaneous `bit_valid`; that bit is discarded and no completion occurs.
  - Does not affect `word_out`, `word_valid` or `overrun`.
- **`word_ready` with `word_valid`=0:** ignored.
- **Unused `acc` positions:** the partial word is zero-filled, because `acc` clears on completion and on clear.

## Timing
- **Reset values:** `word_out`=0, `word_valid`=0, `bit_count`=0, `overrun`=0; `acc`=0 internally. `rst` wins over every other input on the same edge.
- **Reset mid-word:** the partial word is lost and any word in the output register is lost.
- **Latency:** the WIDTH-th bit is accepted on edge N. `word_valid`=1 and the new `word_out` are visible after edge N, i.e. during the cycle following the last bit.
- **Throughput:** one bit per clock, continuous. At WIDTH≥2, a consumer with `word_ready` tied to 1 never causes an overrun.
- **`bit_count`:** registered and equal to `cnt`. It reads 0 in the cycle after completion.
- **`overrun`:** rises in the cycle after the dropping edge.
- **`word_valid`:** deasserts in the cycle after the handshake edge, unless a candidate loaded on that same edge.
- **Combinational paths:** none from inputs to outputs.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs → `word_out`=0, `word_valid`=0, `bit_count`=0, `overrun`=0.
- **LSB-first word:** `LSB_FIRST`=1, `word_ready`=1, 32 contiguous bits of 0xA5C30F81 sent LSB first → exactly one `word_valid` cycle, the cycle after the 32nd bit, with `word_out`=0xA5C30F81; `bit_count` sequence 0..31,0. Repeat with `LSB_FIRST`=0, sending the MSB first → same word.
- **Overrun:** `word_ready`=0 while sending 0x12345678 then 0x9ABCDEF0 → `word_out` stays 0x12345678, `overrun`=1 after the 64th bit edge. Raise `word_ready` → one handshake, then `word_valid`=0; `overrun` remains 1.
- **Handshake coincides with completion:** `word_ready`=0 through the first word (0x11111111), pulse `word_ready`=1 on the edge accepting the last bit of 0x22222222 → `overrun`=0, `word_valid` stays 1, `word_out`=0x22222222.
- **word_clear:** send 10 bits of 1, then `word_clear`=1 together with `bit_valid`=1, then 32 bits of 0x0000FFFF → `bit_count`=0 after the clear, output 0x0000FFFF with no residue; `word_valid` is unaffected by the clear.
- **Reset mid-word:** 17 bits sent, then `rst` for 1 cycle, then 32 bits of 0xDEADBEEF → `bit_count`=0 after reset, output 0xDEADBEEF, `overrun`=0.
